filter_stim_seq: RTL and testbench

- Sequences a fixed-point stimulus program into the msdsl filter's `v_in` and captures `v_out` after each step's settle time.
- Holds an N-entry table of {value, hold cycles}; plays it once per `start`; hands each captured sample to a host (VIO/JTAG bridge) over a valid/ready port.
- Sits between the emulator control logic and the filter instance, clocked on the emulator clock.

---
 rtl/filter_stim_pkg.sv | 31 +++
 rtl/filter_stim_table.sv | 51 +++++
 rtl/filter_stim_seq.sv | 198 +++++++++++++++++++
 tb/tb_filter_stim_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_stim_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : filter_stim_pkg                                             |
// | Description : Shared types and default sizes for the filter stimulus      |
// |               sequencer (state encoding, table entry layout).             |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

package filter_stim_pkg;

  localparam int DEF_WIDTH   = 18;
  localparam int DEF_N_STEPS = 8;
  localparam int DEF_HOLD_W  = 16;

  // Sequencer states; 2-bit encoding is explicit so the register width is fixed.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } state_e;

  // One stimulus program step at the default word sizes.
  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] val;
    logic [DEF_HOLD_W-1:0]       hold;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/filter_stim_table.sv
// +--------------------------------------------------------------------------+
// | Module      : filter_stim_table                                           |
// | Description : N_STEPS x {value, hold} register file, one synchronous      |
// |               write port and one combinational read port. No reset on     |
// |               the storage; contents are defined only once written.        |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module filter_stim_table
  import filter_stim_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int N_STEPS = DEF_N_STEPS,
  parameter int HOLD_W  = DEF_HOLD_W,
  parameter int IDX_W   = $clog2(N_STEPS)
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        waddr_i,
  input  logic signed [WIDTH-1:0] wval_i,
  input  logic [HOLD_W-1:0]       whold_i,
  input  logic [IDX_W-1:0]        raddr_i,
  output logic signed [WIDTH-1:0] rval_o,
  output logic [HOLD_W-1:0]       rhold_o
);

  logic signed [WIDTH-1:0] val_q  [N_STEPS];
  logic [HOLD_W-1:0]       hold_q [N_STEPS];

  // Write port: entry becomes visible on the read port the following cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      val_q[waddr_i]  <= wval_i;
      hold_q[waddr_i] <= whold_i;
    end
  end

  // Read port: out-of-range addresses (non power-of-two depth) read as zero.
  always_comb begin
    rval_o  = '0;
    rhold_o = '0;
    if (int'(raddr_i) < N_STEPS) begin
      rval_o  = val_q[raddr_i];
      rhold_o = hold_q[raddr_i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/filter_stim_seq.sv
// +--------------------------------------------------------------------------+
// | Module      : filter_stim_seq                                             |
// | Description : Plays a {value, hold} stimulus program into the filter      |
// |               input, captures the filter output at the end of each step   |
// |               and hands it to the host over a valid/ready port.           |
// |               Optional macro FILTER_STIM_SEQ_PEAK_EN adds pk_max/pk_min   |
// |               run peak trackers on the filter output.                     |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module filter_stim_seq
  import filter_stim_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int N_STEPS = DEF_N_STEPS,
  parameter int HOLD_W  = DEF_HOLD_W,
  parameter int IDX_W   = $clog2(N_STEPS)
) (
  input  logic                    emu_clk,
  input  logic                    emu_rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_addr,
  input  logic signed [WIDTH-1:0] cfg_val,
  input  logic [HOLD_W-1:0]       cfg_hold,
  output logic signed [WIDTH-1:0] v_in,
  input  logic signed [WIDTH-1:0] v_out,
  output logic                    smp_valid,
  input  logic                    smp_ready,
  output logic signed [WIDTH-1:0] smp_data,
  output logic [IDX_W-1:0]        smp_idx,
  output logic                    busy,
  output logic                    done
`ifdef FILTER_STIM_SEQ_PEAK_EN
  ,
  output logic signed [WIDTH-1:0] pk_max,
  output logic signed [WIDTH-1:0] pk_min
`endif
);

  // A hold of zero is treated as one cycle so the counter never underflows.
  function automatic logic [HOLD_W-1:0] hold_floor(input logic [HOLD_W-1:0] h);
    return (h == '0) ? HOLD_W'(1) : h;
  endfunction

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [HOLD_W-1:0]       cnt_q;
  logic signed [WIDTH-1:0] v_in_q;
  logic                    smp_valid_q;
  logic signed [WIDTH-1:0] smp_data_q;
  logic [IDX_W-1:0]        smp_idx_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    wr_en;
  logic [IDX_W-1:0]        rd_addr;
  logic signed [WIDTH-1:0] tab_val;
  logic [HOLD_W-1:0]       tab_hold;
  logic                    wr_bypass;
  logic signed [WIDTH-1:0] nxt_val;
  logic [HOLD_W-1:0]       nxt_hold;
  logic                    run_go;

  assign wr_en = cfg_we && !busy_q;

  // While running, look ahead at the next step; otherwise present step 0 for a start.
  assign rd_addr = busy_q ? (idx_q + IDX_W'(1)) : '0;

  // A write landing on the same edge as the read is forwarded, so start plus
  // cfg_we to entry 0 plays the freshly written value.
  assign wr_bypass = wr_en && (cfg_addr == rd_addr);
  assign nxt_val   = wr_bypass ? cfg_val  : tab_val;
  assign nxt_hold  = wr_bypass ? cfg_hold : tab_hold;

  assign run_go = start && !abort && ((state_q == IDLE) || (state_q == DONE));

  filter_stim_table #(
    .WIDTH   (WIDTH),
    .N_STEPS (N_STEPS),
    .HOLD_W  (HOLD_W),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk_i   (emu_clk),
    .we_i    (wr_en),
    .waddr_i (cfg_addr),
    .wval_i  (cfg_val),
    .whold_i (cfg_hold),
    .raddr_i (rd_addr),
    .rval_o  (tab_val),
    .rhold_o (tab_hold)
  );

  // Sequencer FSM with all outputs registered; abort overrides every state.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= HOLD_W'(1);
      v_in_q      <= '0;
      smp_valid_q <= 1'b0;
      smp_data_q  <= '0;
      smp_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort) begin
      state_q     <= IDLE;
      v_in_q      <= '0;
      smp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            idx_q   <= '0;
            v_in_q  <= nxt_val;
            cnt_q   <= hold_floor(nxt_hold);
            state_q <= HOLD;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_W'(1)) begin
            smp_data_q  <= v_out;
            smp_idx_q   <= idx_q;
            smp_valid_q <= 1'b1;
            state_q     <= WAIT_ACK;
          end else begin
            cnt_q <= cnt_q - HOLD_W'(1);
          end
        end
        WAIT_ACK: begin
          if (smp_valid_q && smp_ready) begin
            smp_valid_q <= 1'b0;
            if (idx_q == IDX_W'(N_STEPS - 1)) begin
              v_in_q  <= '0;
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              v_in_q  <= nxt_val;
              cnt_q   <= hold_floor(nxt_hold);
              state_q <= HOLD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign v_in      = v_in_q;
  assign smp_valid = smp_valid_q;
  assign smp_data  = smp_data_q;
  assign smp_idx   = smp_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef FILTER_STIM_SEQ_PEAK_EN
  logic                    pk_first_q;
  logic signed [WIDTH-1:0] pk_max_q;
  logic signed [WIDTH-1:0] pk_min_q;

  // Track signed extremes of v_out over the HOLD cycles of the current run.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      pk_first_q <= 1'b0;
      pk_max_q   <= '0;
      pk_min_q   <= '0;
    end else if (run_go) begin
      pk_first_q <= 1'b1;
    end else if (state_q == HOLD) begin
      pk_first_q <= 1'b0;
      if (pk_first_q) begin
        pk_max_q <= v_out;
        pk_min_q <= v_out;
      end else begin
        if (v_out > pk_max_q) pk_max_q <= v_out;
        if (v_out < pk_min_q) pk_min_q <= v_out;
      end
    end
  end

  assign pk_max = pk_max_q;
  assign pk_min = pk_min_q;
`else
  logic unused_run_go;
  assign unused_run_go = run_go;
`endif

endmodule

`default_nettype wire

// File: tb/tb_filter_stim_seq.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_filter_stim_seq                                          |
// | Description : Self-checking bench for filter_stim_seq. v_out is tied to   |
// |               v_in, so every captured sample must equal the table value.  |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_filter_stim_seq;

  localparam int WIDTH   = 18;
  localparam int N_STEPS = 8;
  localparam int HOLD_W  = 16;
  localparam int IDX_W   = 3;
  localparam int ONE     = 1 << 14;  // 1.0 in the bench's fixed-point scale
  localparam int BUDGET  = 400;

  logic                    emu_clk   = 1'b0;
  logic                    emu_rst_n = 1'b0;
  logic                    start     = 1'b0;
  logic                    abort     = 1'b0;
  logic                    cfg_we    = 1'b0;
  logic [IDX_W-1:0]        cfg_addr  = '0;
  logic signed [WIDTH-1:0] cfg_val   = '0;
  logic [HOLD_W-1:0]       cfg_hold  = '0;
  logic                    smp_ready = 1'b0;
  logic signed [WIDTH-1:0] v_in;
  logic signed [WIDTH-1:0] v_out;
  logic                    smp_valid;
  logic signed [WIDTH-1:0] smp_data;
  logic [IDX_W-1:0]        smp_idx;
  logic                    busy;
  logic                    done;
`ifdef FILTER_STIM_SEQ_PEAK_EN
  logic signed [WIDTH-1:0] pk_max;
  logic signed [WIDTH-1:0] pk_min;
`endif

  assign v_out = v_in;

  filter_stim_seq #(
    .WIDTH(WIDTH), .N_STEPS(N_STEPS), .HOLD_W(HOLD_W), .IDX_W(IDX_W)
  ) dut (
    .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .start(start), .abort(abort),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_val(cfg_val), .cfg_hold(cfg_hold),
    .v_in(v_in), .v_out(v_out), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .smp_data(smp_data), .smp_idx(smp_idx), .busy(busy), .done(done)
`ifdef FILTER_STIM_SEQ_PEAK_EN
    , .pk_max(pk_max), .pk_min(pk_min)
`endif
  );

  always #5 emu_clk = ~emu_clk;

  int cyc = 0;
  always @(posedge emu_clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [WIDTH-1:0] data;
    int                      idx;
    int                      gap;
  } exp_t;

  exp_t                    sb_q[$];
  logic signed [WIDTH-1:0] m_val  [N_STEPS];
  int                      m_hold [N_STEPS];
  int                      checks   = 0;
  int                      failures = 0;
  int                      t_ref    = 0;

  function automatic int hfl(input int h);
    return (h == 0) ? 1 : h;
  endfunction

  task automatic tick();
    @(negedge emu_clk);
  endtask

  task automatic cfg_write(input int a, input int v, input int h, input bit upd);
    cfg_we   = 1'b1;
    cfg_addr = IDX_W'(a);
    cfg_val  = WIDTH'(v);
    cfg_hold = HOLD_W'(h);
    if (upd) begin
      m_val[a]  = WIDTH'(v);
      m_hold[a] = h;
    end
    tick();
    cfg_we = 1'b0;
  endtask

  // Pulse start (optionally with a same-cycle table write) and queue the expected run.
  task automatic start_run(input bit wr, input int wa, input int wv, input int wh);
    if (wr) begin
      cfg_we = 1'b1; cfg_addr = IDX_W'(wa); cfg_val = WIDTH'(wv); cfg_hold = HOLD_W'(wh);
      m_val[wa] = WIDTH'(wv); m_hold[wa] = wh;
    end
    start = 1'b1;
    sb_q.delete();
    for (int k = 0; k < N_STEPS; k++) begin
      exp_t e;
      e.data = m_val[k]; e.idx = k; e.gap = hfl(m_hold[k]) + 1;
      sb_q.push_back(e);
    end
    t_ref = cyc;
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
  endtask

  // Consume n samples; optionally withhold ready for stall_cyc cycles at stall_idx.
  task automatic collect(input int n, input int stall_idx, input int stall_cyc);
    int got = 0, budget = 0, stall_left = stall_cyc;
    bit seen = 0, chk_next = 0, last = 0;
    logic signed [WIDTH-1:0] exp_vin = '0;
    exp_t e;
    smp_ready = 1'b1;
    while ((got < n || chk_next) && budget < BUDGET) begin
      if (chk_next) begin
        chk_next = 0;
        checks++;
        if (smp_valid !== 1'b0 || v_in !== exp_vin || busy !== !last || done !== last)
          begin failures++; $display("FAIL after_ack valid=%b v_in=%0d busy=%b done=%b required valid=0 v_in=%0d busy=%b done=%b",
                            smp_valid, v_in, busy, done, exp_vin, !last, last); end
      end
      if (got < n && smp_valid === 1'b1) begin
        e = sb_q[0];
        if (!seen) begin
          seen = 1;
          checks++;
          if (cyc - t_ref != e.gap) begin failures++;
            $display("FAIL sample_latency idx=%0d actual=%0d required=%0d", e.idx, cyc - t_ref, e.gap); end
          checks++;
          if (smp_data !== e.data || smp_idx !== IDX_W'(e.idx)) begin failures++;
            $display("FAIL sample_data actual=%0d/%0d required=%0d/%0d", smp_data, smp_idx, e.data, e.idx); end
        end else begin
          checks++;
          if (smp_data !== e.data || smp_idx !== IDX_W'(e.idx) || v_in !== m_val[e.idx]) begin failures++;
            $display("FAIL stall_stable data=%0d idx=%0d v_in=%0d required=%0d/%0d/%0d",
                     smp_data, smp_idx, v_in, e.data, e.idx, m_val[e.idx]); end
        end
        if (e.idx == stall_idx && stall_left > 0) begin
          smp_ready = 1'b0;
          stall_left--;
        end else begin
          smp_ready = 1'b1;
          void'(sb_q.pop_front());
          got++; seen = 0; t_ref = cyc; chk_next = 1;
          last    = (e.idx == N_STEPS - 1);
          exp_vin = last ? '0 : m_val[e.idx + 1];
        end
      end
      if (got < n || chk_next) begin tick(); budget++; end
    end
    if (got < n) begin
      checks++; failures++;
      $display("FAIL collect_timeout samples=%0d required=%0d", got, n);
    end
  endtask

  task automatic test_reset();
    emu_rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (v_in !== '0 || smp_valid !== 1'b0 || smp_data !== '0) begin failures++;
      $display("FAIL reset_data v_in=%0d valid=%b data=%0d required 0", v_in, smp_valid, smp_data); end
    checks++;
    if (smp_idx !== '0 || busy !== 1'b0 || done !== 1'b0) begin failures++;
      $display("FAIL reset_ctrl idx=%0d busy=%b done=%b required 0", smp_idx, busy, done); end
`ifdef FILTER_STIM_SEQ_PEAK_EN
    checks++;
    if (pk_max !== '0 || pk_min !== '0) begin failures++;
      $display("FAIL reset_peak max=%0d min=%0d required 0", pk_max, pk_min); end
`endif
    emu_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sequence();
    int vals [N_STEPS] = '{ONE/4, -ONE/2, ONE, -ONE, ONE/8, ONE/2, -3*ONE/4, 3*ONE/8};
    int holds[N_STEPS] = '{3, 1, 0, 2, 4, 1, 2, 5};
    for (int k = 0; k < N_STEPS; k++) cfg_write(k, vals[k], holds[k], 1);
    start_run(0, 0, 0, 0);
    checks++;
    if (busy !== 1'b1 || v_in !== m_val[0] || done !== 1'b0) begin failures++;
      $display("FAIL start_load busy=%b v_in=%0d done=%b required 1/%0d/0", busy, v_in, done, m_val[0]); end
    collect(N_STEPS, -1, 0);
  endtask

  task automatic test_stall();
    start_run(0, 0, 0, 0);
    collect(N_STEPS, 2, 10);
  endtask

  task automatic test_abort();
    start_run(0, 0, 0, 0);
    collect(4, -1, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || v_in !== '0 || smp_valid !== 1'b0 || done !== 1'b0) begin failures++;
      $display("FAIL abort busy=%b v_in=%0d valid=%b done=%b required all 0", busy, v_in, smp_valid, done); end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || v_in !== '0) begin failures++;
      $display("FAIL abort_beats_start busy=%b v_in=%0d required 0/0", busy, v_in); end
    start_run(0, 0, 0, 0);
    collect(N_STEPS, -1, 0);
  endtask

  task automatic test_cfg_busy();
    start_run(0, 0, 0, 0);
    cfg_write(1, 3*ONE/4, 1, 0);  // busy: must be ignored, model untouched
    collect(N_STEPS, -1, 0);
    cfg_write(1, 3*ONE/4, 1, 1);
    start_run(1, 0, -ONE/4, 2);   // write to entry 0 in the start cycle
    collect(N_STEPS, -1, 0);
  endtask

  task automatic test_async_reset();
    int b = 0;
    smp_ready = 1'b0;
    start_run(0, 0, 0, 0);
    while (smp_valid !== 1'b1 && b < 100) begin tick(); b++; end
    checks++;
    if (smp_valid !== 1'b1) begin failures++;
      $display("FAIL wait_ack_reach valid=%b required 1", smp_valid); end
    #2 emu_rst_n = 1'b0;
    #1;
    checks++;
    if ({v_in, smp_data, smp_idx, smp_valid, busy, done} !== '0) begin failures++;
      $display("FAIL async_reset v_in=%0d data=%0d idx=%0d valid=%b busy=%b done=%b required all 0",
               v_in, smp_data, smp_idx, smp_valid, busy, done); end
    tick();
    emu_rst_n = 1'b1;
    tick();
    start_run(0, 0, 0, 0);
    collect(N_STEPS, -1, 0);
  endtask

`ifdef FILTER_STIM_SEQ_PEAK_EN
  task automatic test_peak();
    int vals[N_STEPS] = '{ONE/2, -5*ONE/4, ONE, 0, 0, 0, 0, 0};
    for (int k = 0; k < N_STEPS; k++) cfg_write(k, vals[k], 1, 1);
    start_run(0, 0, 0, 0);
    collect(N_STEPS, -1, 0);
    checks++;
    if (pk_max !== WIDTH'(ONE) || pk_min !== WIDTH'(-5*ONE/4)) begin failures++;
      $display("FAIL peak max=%0d min=%0d required %0d/%0d", pk_max, pk_min, ONE, -5*ONE/4); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_abort();
    test_cfg_busy();
    test_async_reset();
`ifdef FILTER_STIM_SEQ_PEAK_EN
    test_peak();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
